// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared definitions for the branch target predictor:
//               default geometry, 2-bit counter encodings and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int WORD_SIZE_DEFAULT  = 16;
    localparam int INDEX_BITS_DEFAULT = 8;

    // 2-bit saturating direction counter encodings
    localparam logic [1:0] c_CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] c_CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] c_CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] c_CTR_ST  = 2'b11;  // strongly taken

    // Table controller states
    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } bp_state_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Next-state logic of a 2-bit saturating direction counter.
//               Counts up on taken, down on not-taken, clamps at 11 / 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Saturating increment/decrement of the counter
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != c_CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != c_CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with 2-bit direction
//               counters. Combinational lookup, registered update from the
//               resolve stage, and a sweep FSM that clears the table after
//               reset or a flush request.
//               Optional macro BP_STATS_EN enables saturating performance
//               counters (lookups, mispredicts); otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEFAULT,
    parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 pc_valid,
    output logic [WORD_SIZE-1:0] next_pc,
    output logic                 pred_taken,
    output logic                 ready,
    input  logic                 upd_valid,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 flush_all,
    output logic [31:0]          stat_lookups,
    output logic [31:0]          stat_mispredicts
);

    localparam int ENTRIES  = 2 ** INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    // ------------------------------------------------------------------
    // Table storage (not reset; cleared by the sweep)
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_BITS-1:0]  r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    logic [1:0]           r_ctr    [ENTRIES];

    bp_state_t             r_state;
    bp_state_t             w_state_next;
    logic [INDEX_BITS-1:0] r_sweep_idx;

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;

    assign w_lk_idx   = pc[INDEX_BITS-1:0];
    assign w_lk_tag   = pc[WORD_SIZE-1:INDEX_BITS];
    assign w_lk_hit   = ready & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken = w_lk_hit & r_ctr[w_lk_idx][1];
    assign next_pc    = pred_taken ? r_target[w_lk_idx]
                                   : pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_up_accept;
    logic [1:0]            w_ctr_next;

    assign w_up_idx    = upd_pc[INDEX_BITS-1:0];
    assign w_up_tag    = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign w_up_hit    = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
    // A flush request wins over a simultaneous update
    assign w_up_accept = upd_valid & ready & ~flush_all;

    bp_sat_counter u_sat_counter (
        .ctr      (r_ctr[w_up_idx]),
        .taken    (upd_taken),
        .ctr_next (w_ctr_next)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SWEEP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: sweep until the last index is cleared, flush restarts it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SWEEP: begin
                if (!flush_all && (r_sweep_idx == {INDEX_BITS{1'b1}})) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (flush_all) begin
                    w_state_next = ST_SWEEP;
                end
            end
            default: w_state_next = ST_SWEEP;
        endcase
    end

    // Outputs: table usable only once the sweep has finished
    always_comb begin
        ready = (r_state == ST_READY);
    end

    // Sweep pointer: restarts on flush, advances once per sweep edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sweep_idx <= '0;
        end else if (flush_all) begin
            r_sweep_idx <= '0;
        end else if (r_state == ST_SWEEP) begin
            r_sweep_idx <= r_sweep_idx + 1'b1;
        end
    end

    // Table writes: sweep clears entries, accepted updates train/allocate
    always_ff @(posedge clk) begin
        if (r_state == ST_SWEEP) begin
            if (!flush_all) begin
                r_valid[r_sweep_idx] <= 1'b0;
                r_ctr[r_sweep_idx]   <= c_CTR_WNT;
            end
        end else if (w_up_accept) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_ctr_next;
                if (upd_taken) begin
                    r_target[w_up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target;
                r_ctr[w_up_idx]    <= c_CTR_WT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    // Saturating event counters for lookups and accepted mispredicts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pc_valid && ready && (stat_lookups != 32'hFFFF_FFFF)) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (w_up_accept && upd_mispredict &&
                (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats   = &{1'b0, pc_valid, upd_mispredict};
    assign stat_lookups     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Directed self-checking bench for branch_target_predictor
//               (WORD_SIZE=16, INDEX_BITS=8) with an expected-output queue.
//               Stat expectations follow BP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_valid;
    logic [15:0] next_pc;
    logic        pred_taken;
    logic        ready;
    logic        upd_valid;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        flush_all;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    typedef struct packed {
        logic        rdy;
        logic        tk;
        logic [15:0] nxt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    branch_target_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .next_pc          (next_pc),
        .pred_taken       (pred_taken),
        .ready            (ready),
        .upd_valid        (upd_valid),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .flush_all        (flush_all),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the live outputs
    task automatic check_out();
        exp_t        e;
        string       t;
        logic [17:0] obs;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {ready, pred_taken, next_pc};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed={rdy,tk,next}=%h expected=%h", t, obs, e);
        end
    endtask

    // Queue an expectation, let combinational outputs settle, then compare
    task automatic expect_out(input string tag, input logic rdy,
                              input logic tk, input logic [15:0] nxt);
        exp_t e;
        e = '{rdy: rdy, tk: tk, nxt: nxt};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Present a PC in READY, check the prediction, then advance one cycle
    task automatic lookup(input string tag, input logic [15:0] p,
                          input logic tk, input logic [15:0] nxt);
        pc = p;
        expect_out(tag, 1'b1, tk, nxt);
        @(posedge clk); #1;
    endtask

    // Drive a resolved-branch update for exactly one edge
    task automatic update(input logic [15:0] p, input logic [15:0] tgt,
                          input logic tk, input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = p;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_mispredict = misp;
        @(posedge clk); #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        pc             = 16'h0010;
        pc_valid       = 1'b0;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_pc         = 16'h0000;
        upd_target     = 16'h0000;
        flush_all      = 1'b0;

        // Reset state
        @(posedge clk); #1;
        expect_out("reset_outputs", 1'b0, 1'b0, 16'h0011);
        check32("reset_stat_lookups", stat_lookups, 32'd0);
        check32("reset_stat_mispredicts", stat_mispredicts, 32'd0);

        // Release reset: 256 sweep edges with ready low
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            expect_out("init_sweep", 1'b0, 1'b0, 16'h0011);
            @(posedge clk); #1;
        end
        expect_out("init_ready", 1'b1, 1'b0, 16'h0011);

        // Taken update allocates, next cycle predicts taken
        update(16'h0123, 16'h0456, 1'b1, 1'b1);
        lookup("alloc_taken", 16'h0123, 1'b1, 16'h0456);

        // Two not-taken updates: 10 -> 01 -> 00
        update(16'h0123, 16'h0000, 1'b0, 1'b0);
        lookup("nt1_0123", 16'h0123, 1'b0, 16'h0124);
        update(16'h0123, 16'h0000, 1'b0, 1'b0);
        lookup("nt2_0123", 16'h0123, 1'b0, 16'h0124);

        // Four taken updates: 00 -> 01 -> 10 -> 11 -> 11
        update(16'h0123, 16'h0456, 1'b1, 1'b0);
        lookup("t1_0123", 16'h0123, 1'b0, 16'h0124);
        update(16'h0123, 16'h0456, 1'b1, 1'b0);
        lookup("t2_0123", 16'h0123, 1'b1, 16'h0456);
        update(16'h0123, 16'h0456, 1'b1, 1'b0);
        lookup("t3_0123", 16'h0123, 1'b1, 16'h0456);
        update(16'h0123, 16'h0456, 1'b1, 1'b0);
        lookup("t4_sat", 16'h0123, 1'b1, 16'h0456);

        // One not-taken from saturation: 11 -> 10, still taken
        update(16'h0123, 16'h0000, 1'b0, 1'b0);
        lookup("nt_after_sat", 16'h0123, 1'b1, 16'h0456);

        // Aliasing on index 0x23 and replacement
        lookup("alias_miss", 16'h0223, 1'b0, 16'h0224);
        update(16'h0223, 16'h0300, 1'b1, 1'b1);
        lookup("alias_replaced", 16'h0223, 1'b1, 16'h0300);
        lookup("old_tag_miss", 16'h0123, 1'b0, 16'h0124);

        // Not-taken miss leaves the aliased entry intact
        update(16'h0323, 16'h0abc, 1'b0, 1'b0);
        lookup("nt_miss_noalloc", 16'h0323, 1'b0, 16'h0324);
        lookup("nt_miss_keep", 16'h0223, 1'b1, 16'h0300);

        // PC wrap-around on a miss
        lookup("wrap", 16'hFFFF, 1'b0, 16'h0000);

        // Same-cycle update is not visible to the lookup
        pc             = 16'h0555;
        upd_valid      = 1'b1;
        upd_pc         = 16'h0555;
        upd_target     = 16'h0777;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b0;
        expect_out("no_bypass", 1'b1, 1'b0, 16'h0556);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        lookup("after_bypass", 16'h0555, 1'b1, 16'h0777);

        // Flush with a simultaneous update: flush wins
        pc             = 16'h0223;
        flush_all      = 1'b1;
        upd_valid      = 1'b1;
        upd_pc         = 16'h0888;
        upd_target     = 16'h0999;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        expect_out("flush_cycle", 1'b1, 1'b1, 16'h0300);
        @(posedge clk); #1;
        flush_all      = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;

        // Sweep after flush; an update mid-sweep is dropped
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin
                upd_valid      = 1'b1;
                upd_pc         = 16'h0123;
                upd_target     = 16'h0abc;
                upd_taken      = 1'b1;
                upd_mispredict = 1'b1;
            end
            expect_out("flush_sweep", 1'b0, 1'b0, 16'h0224);
            @(posedge clk); #1;
            upd_valid      = 1'b0;
            upd_mispredict = 1'b0;
        end
        lookup("post_flush_0123", 16'h0123, 1'b0, 16'h0124);
        lookup("post_flush_0888", 16'h0888, 1'b0, 16'h0889);
        lookup("post_flush_0223", 16'h0223, 1'b0, 16'h0224);
        lookup("post_flush_0555", 16'h0555, 1'b0, 16'h0556);

        // Third accepted mispredicting update
        update(16'h0123, 16'h0abc, 1'b1, 1'b1);
        lookup("realloc_0123", 16'h0123, 1'b1, 16'h0abc);

        // Ten qualified lookups
        pc_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lookup("stat_lookup", 16'h0300 + 16'(i), 1'b0, 16'h0301 + 16'(i));
        end
        pc_valid = 1'b0;

`ifdef BP_STATS_EN
        check32("stat_lookups", stat_lookups, 32'd10);
        check32("stat_mispredicts", stat_mispredicts, 32'd3);
`else
        check32("stat_lookups_off", stat_lookups, 32'd0);
        check32("stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif

        // Reset asserted mid-operation clears outputs immediately
        pc    = 16'h0123;
        reset = 1'b1;
        expect_out("reset_again", 1'b0, 1'b0, 16'h0124);
        check32("reset_again_lookups", stat_lookups, 32'd0);
        check32("reset_again_mispredicts", stat_mispredicts, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, the PC and target width in bits.
REQ-002 SHALL have parameter INDEX_BITS, default 8, giving ENTRIES = 2**INDEX_BITS; the tag is PC[WORD_SIZE-1:INDEX_BITS] and the index is PC[INDEX_BITS-1:0].
REQ-003 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have ports pc (input, WORD_SIZE) and pc_valid (input, 1): fetch PC and its qualifier.
REQ-006 SHALL have ports next_pc (output, WORD_SIZE), pred_taken (output, 1) and ready (output, 1): predicted fetch address, taken prediction, and table-usable flag.
REQ-007 SHALL have ports upd_valid, upd_taken and upd_mispredict (input, 1 each), plus upd_pc and upd_target (input, WORD_SIZE each): resolved-branch update from the resolve stage.
REQ-008 SHALL have port flush_all, input, width 1: requests invalidation of the whole table.
REQ-009 SHALL have ports stat_lookups and stat_mispredicts, output, width 32 each: performance counters.

Function
REQ-010 SHALL store, per entry, a valid bit, a tag, a WORD_SIZE target and a 2-bit counter: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
REQ-011 SHALL compute the lookup combinationally in the same cycle: hit = ready AND valid[idx] AND tag match; pred_taken = hit AND ctr[1].
REQ-012 SHALL drive next_pc = target when pred_taken = 1, otherwise pc+1 modulo 2**WORD_SIZE (0xFFFF wraps to 0x0000).
REQ-013 SHALL process updates only on a clock edge where upd_valid=1 and ready=1; updates arriving while ready=0 are dropped.
REQ-014 SHALL, on an update hit, increment the counter saturating at 11 when upd_taken=1 and decrement it saturating at 00 when upd_taken=0; when upd_taken=1 the target is also overwritten with upd_target.
REQ-015 SHALL, on an update miss with upd_taken=1, allocate or replace the entry: valid=1, new tag, target=upd_target, counter=10.
REQ-016 SHALL leave the table unchanged on an update miss with upd_taken=0.
REQ-017 SHALL NOT bypass an update to a lookup in the same cycle: the lookup sees pre-edge state.
REQ-018 SHALL implement a two-state FSM, SWEEP and READY, with ready=1 only in READY.
- SWEEP: each edge clears valid[sweep_idx], sets counter=01 and increments sweep_idx.
- After the edge that clears index ENTRIES-1, the FSM moves to READY.
REQ-019 SHALL, when flush_all=1 in READY, enter SWEEP with sweep_idx=0 on the next edge; flush_all=1 during SWEEP restarts the sweep at index 0.
REQ-020 SHALL give flush_all priority over a simultaneous update, discarding the update.

Reset
REQ-021 SHALL, while reset=1, force state=SWEEP, sweep_idx=0, ready=0, pred_taken=0, next_pc=pc+1 and both stat counters to 0.
REQ-022 SHALL NOT reset the table arrays asynchronously; they are cleared by the sweep. Reset asserted mid-sweep restarts the sweep.

Configuration
REQ-023 SHALL support macro BP_STATS_EN.
- Defined: stat_lookups increments on each edge with pc_valid=1 and ready=1; stat_mispredicts increments on each accepted update with upd_mispredict=1; both saturate at 0xFFFFFFFF.
- Undefined: both outputs are constant 0 and no counter logic is present.

Structure
REQ-024 SHALL place the counter encodings, the FSM state typedef and default parameter values in shared package bp_pkg.
REQ-025 SHALL implement the 2-bit saturating next-state logic in sub-module bp_sat_counter, instantiated once for the update path.

Verification (WORD_SIZE=16, INDEX_BITS=8)
REQ-026 SHALL cover: release reset with pc=0x0010 -> ready=0 and next_pc=0x0011 for 256 edges, then ready=1.
REQ-027 SHALL cover: taken update pc=0x0123, target=0x0456 -> the next cycle pc=0x0123 gives pred_taken=1, next_pc=0x0456.
REQ-028 SHALL cover: two not-taken updates on 0x0123 -> next_pc=0x0124; then four taken updates -> counter holds at 11; then one not-taken -> next_pc stays 0x0456.
REQ-029 SHALL cover aliasing and wrap-around: lookup 0x0223 -> miss, next_pc=0x0224; taken update 0x0223 -> 0x0300 replaces the entry, and 0x0123 now misses; lookup pc=0xFFFF on a miss -> next_pc=0x0000.
REQ-030 SHALL cover: flush_all in READY, plus an update during the sweep -> ready=0 for 256 edges, the update is dropped, and 0x0123 misses afterwards.
REQ-031 SHALL cover, with BP_STATS_EN defined: 10 valid lookups and 3 mispredicting updates -> stat_lookups=10, stat_mispredicts=3.
